// File: rtl/inside_scan_pkg.sv
// Shared types and constants for the inside-match scanner: FSM states,
// default geometry and the saturating result-counter helper.
package inside_scan_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_W     = 8;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/inside_match_table.sv
// Match table: un-reset data storage, resettable valid bits, one write port
// (clear wins over write) and one combinational read port.
module inside_match_table
  import inside_scan_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [W-1:0]  tbl_wdata,
  input  logic          tbl_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Entry data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      mem_q[tbl_addr] <= tbl_wdata;
    end
  end

  // Valid-bit next state: clear has priority so a same-cycle write stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (tbl_clr) begin
      valid_d = {DEPTH{1'b0}};
    end else if (tbl_we) begin
      valid_d[tbl_addr] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid-bit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign rd_valid = valid_q[rd_addr];

endmodule

// File: rtl/inside_match_scanner.sv
// Sequential table-membership scanner: accepts one sample, walks the table one
// entry per cycle, and presents hit/index on a valid/ready result port.
module inside_match_scanner
  import inside_scan_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [W-1:0]     tbl_wdata,
  input  logic             tbl_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_hit,
  output logic [AW-1:0]    out_idx,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     sample_q, sample_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_hit_q, out_hit_d;
  logic [AW-1:0]    out_idx_q, out_idx_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [W-1:0] rd_data_s;
  logic         rd_valid_s;
  logic         match_s;
  logic         last_s;
  logic         out_hs_s;

  inside_match_table #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .tbl_clr   (tbl_clr),
    .rd_addr   (idx_q),
    .rd_data   (rd_data_s),
    .rd_valid  (rd_valid_s)
  );

  assign match_s  = rd_valid_s && (rd_data_s == sample_q);
  assign last_s   = (idx_q == IDX_LAST);
  assign out_hs_s = out_valid_q && out_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_SCAN; else state_d = ST_IDLE;
      ST_SCAN: if (match_s || last_s) state_d = ST_RESP; else state_d = ST_SCAN;
      ST_RESP: if (out_hs_s) state_d = ST_IDLE; else state_d = ST_RESP;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM output/datapath next-state; out_valid lags RESP entry by one cycle.
  always_comb begin
    sample_d    = sample_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sample_d = in_data;
          idx_d    = {AW{1'b0}};
        end else begin
          sample_d = sample_q;
        end
      end
      ST_SCAN: begin
        if (match_s) begin
          out_hit_d  = 1'b1;
          out_idx_d  = idx_q;
          out_data_d = sample_q;
        end else if (last_s) begin
          out_hit_d  = 1'b0;
          out_idx_d  = {AW{1'b0}};
          out_data_d = sample_q;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      ST_RESP: begin
        out_valid_d = !out_hs_s;
        if (out_hs_s && out_hit_q) begin
          hit_cnt_d = sat_inc(hit_cnt_q);
        end else if (out_hs_s) begin
          miss_cnt_d = sat_inc(miss_cnt_q);
        end else begin
          hit_cnt_d = hit_cnt_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q    <= {W{1'b0}};
      idx_q       <= {AW{1'b0}};
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= {AW{1'b0}};
      out_data_q  <= {W{1'b0}};
      hit_cnt_q   <= {CNT_W{1'b0}};
      miss_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      sample_q    <= sample_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_hit    = out_hit_q;
  assign out_idx    = out_idx_q;
  assign out_data   = out_data_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_inside_match_scanner.sv
// Directed bench for inside_match_scanner with hand-computed expectations.
module tb_inside_match_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [7:0] tbl_wdata;
  logic       tbl_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_hit;
  logic [2:0] out_idx;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int lat;

  always #5 clk = ~clk;

  inside_match_scanner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_wdata  (tbl_wdata),
    .tbl_clr    (tbl_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hit    (out_hit),
    .out_idx    (out_idx),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tbl_write(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    tbl_we    = 1'b1;
    tbl_addr  = addr;
    tbl_wdata = data;
    @(negedge clk);
    tbl_we    = 1'b0;
  endtask

  // Offer one sample and return the number of edges from acceptance to out_valid.
  task automatic send(input logic [7:0] data, output int n);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tbl_we = 1'b0;
    tbl_addr = 3'd0; tbl_wdata = 8'h00; tbl_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_hit", out_hit, 0);
    check_val("rst_out_idx", out_idx, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_hit_count", hit_count, 0);
    check_val("rst_miss_count", miss_count, 0);

    for (int i = 0; i < 8; i++) tbl_write(3'(i), 8'(3 * i));

    send(8'd12, lat);
    check_val("hit12_lat", lat, 6);
    check_val("hit12_hit", out_hit, 1);
    check_val("hit12_idx", out_idx, 4);
    check_val("hit12_data", out_data, 12);
    check_val("hit12_in_ready", in_ready, 0);
    take();
    check_val("hit12_valid_drop", out_valid, 0);
    check_val("hit12_hit_count", hit_count, 1);

    send(8'd13, lat);
    check_val("miss13_lat", lat, 9);
    check_val("miss13_hit", out_hit, 0);
    check_val("miss13_idx", out_idx, 0);
    check_val("miss13_data", out_data, 13);
    take();
    check_val("miss13_miss_count", miss_count, 1);
    check_val("miss13_hit_count", hit_count, 1);

    tbl_write(3'd2, 8'h11);
    tbl_write(3'd5, 8'h11);
    send(8'h11, lat);
    check_val("dup_lat", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val("hold_valid", out_valid, 1);
      check_val("hold_idx", out_idx, 2);
      check_val("hold_data", out_data, 8'h11);
      check_val("hold_in_ready", in_ready, 0);
    end
    take();
    check_val("dup_hit_count", hit_count, 2);
    check_val("dup_in_ready", in_ready, 1);

    // Overwrite entry 3 with the sample in the very cycle entry 3 is compared.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 tbl_we = 1'b1; tbl_addr = 3'd3; tbl_wdata = 8'h77;
    @(posedge clk);
    #1 tbl_we = 1'b0;
    lat = 4;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("samecyc_lat", lat, 9);
    check_val("samecyc_hit", out_hit, 0);
    take();
    check_val("samecyc_miss_count", miss_count, 2);

    @(negedge clk);
    tbl_clr = 1'b1; tbl_we = 1'b1; tbl_addr = 3'd0; tbl_wdata = 8'h00;
    @(negedge clk);
    tbl_clr = 1'b0; tbl_we = 1'b0;
    send(8'h00, lat);
    check_val("clrwe_lat", lat, 9);
    check_val("clrwe_hit", out_hit, 0);
    check_val("clrwe_idx", out_idx, 0);
    take();
    check_val("clrwe_miss_count", miss_count, 3);

    tbl_write(3'd0, 8'hAA);
    tbl_write(3'd7, 8'hBB);
    send(8'hAA, lat);
    check_val("first_lat", lat, 2);
    check_val("first_hit", out_hit, 1);
    check_val("first_idx", out_idx, 0);
    take();
    send(8'hBB, lat);
    check_val("last_lat", lat, 9);
    check_val("last_hit", out_hit, 1);
    check_val("last_idx", out_idx, 7);
    take();
    check_val("pre_sat_hit_count", hit_count, 4);

    for (int n = 0; n < 300; n++) begin
      send(8'hAA, lat);
      take();
    end
    check_val("sat_hit_count", hit_count, 255);
    check_val("sat_miss_count", miss_count, 3);

    // Reset in the middle of a long scan.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hBB;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_hit_count", hit_count, 0);
    check_val("midrst_miss_count", miss_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("midrst_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    check_val("midrst_no_result", out_valid, 0);
    check_val("midrst_counts", {hit_count, miss_count}, 0);

    send(8'hBB, lat);
    check_val("postrst_lat", lat, 9);
    check_val("postrst_hit", out_hit, 0);
    take();
    check_val("postrst_miss_count", miss_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inside_match_scanner.md
INSIDE_MATCH_SCANNER -- requirements
Module: inside_match_scanner

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the number of match-table entries (power of two, 2..16).
REQ-002 Parameter W, default 8, SHALL set the data and table-entry width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_data as valid (upstream memory-array read stream).
REQ-006 in_ready  output  1  SHALL indicate the scanner accepts a sample this cycle.
REQ-007 in_data  input  W  SHALL be the sample to test for table membership.
REQ-008 tbl_we  input  1  SHALL write tbl_wdata to entry tbl_addr and set that entry's valid bit.
REQ-009 tbl_addr  input  log2(DEPTH)  SHALL be the table write index.
REQ-010 tbl_wdata  input  W  SHALL be the table write value.
REQ-011 tbl_clr  input  1  SHALL clear all entry valid bits.
REQ-012 out_valid  output  1  SHALL mark a result as valid.
REQ-013 out_ready  input  1  SHALL indicate downstream accepts the result.
REQ-014 out_data  output  W  SHALL echo the tested sample.
REQ-015 out_hit  output  1  SHALL be 1 when the sample equals any valid entry.
REQ-016 out_idx  output  log2(DEPTH)  SHALL be the lowest matching index on a hit, 0 on a miss.
REQ-017 hit_count, miss_count  output  8 each  SHALL count completed hit and miss results.

Function
REQ-018 FSM SHALL have states IDLE, SCAN, RESP; in_ready SHALL equal (state==IDLE).
REQ-019 IDLE: on in_valid&in_ready SHALL capture in_data, clear the scan index to 0, go to SCAN.
REQ-020 SCAN: each cycle SHALL compare the captured sample against exactly one entry (index i), skipping invalid entries as non-matching.
REQ-021 SCAN: on a match at i SHALL latch out_hit=1, out_idx=i and go to RESP; first (lowest-index) match wins.
REQ-022 SCAN: on no match at i=DEPTH-1 SHALL latch out_hit=0, out_idx=0 and go to RESP; otherwise i increments.
REQ-023 Latency: out_valid SHALL rise k+2 cycles after the acceptance edge for a hit at entry k, and DEPTH+1 cycles after it for a miss.
REQ-024 RESP: out_valid=1 with out_data/out_hit/out_idx held stable until out_valid&out_ready, then SHALL return to IDLE (next sample accepted no earlier than the following cycle).
REQ-025 On the output handshake, hit_count or miss_count SHALL increment by 1, saturating at 255.
REQ-026 A table write in the same cycle as a compare of that entry SHALL not affect that compare; the new value is visible from the next cycle.
REQ-027 tbl_clr and tbl_we in the same cycle: tbl_clr SHALL take priority; no entry becomes valid.
REQ-028 Table writes and clears SHALL be accepted in every state and never stall the FSM.
REQ-029 An empty table (no valid entries) SHALL produce a miss after DEPTH scan cycles.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, out_hit=0, out_idx=0, out_data=0, both counters 0, all valid bits 0.
REQ-031 Reset during SCAN or RESP SHALL abandon the sample with no result emitted and no counter update.
REQ-032 Table data bits SHALL not require reset; only valid bits are reset.

Structure
REQ-033 Package inside_scan_pkg SHALL hold the state enum, default DEPTH/W constants and counter width.
REQ-034 Table storage plus valid bits SHALL be a sub-module inside_match_table (write port, clear, one combinational read port with valid flag).

Verification
REQ-035 Table {0,3,6,9,12,15,18,21} all valid, sample 12 -> out_hit=1, out_idx=4, out_valid 6 cycles after accept, hit_count=1.
REQ-036 Same table, sample 13 -> out_hit=0, out_idx=0, out_valid 9 cycles after accept, miss_count=1.
REQ-037 Entries 2 and 5 both =8'h11, sample 8'h11 -> out_idx=2; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-038 tbl_clr and tbl_we(addr 0, 8'h00) same cycle, then sample 8'h00 -> miss.
REQ-039 300 back-to-back hits with out_ready=1 -> hit_count saturates at 255.
REQ-040 rst_n pulsed low mid-SCAN -> out_valid stays 0, counters 0, in_ready=1 after release.
